// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl -- multi-cycle instruction sequencer for the single-issue RV32 core.
//
// Walks each instruction through FETCH -> DECODE -> EXEC -> WB. It owns every
// sequencing strobe, the PC and the retire counter. It also detects EBREAK
// (halt), illegal encodings and fetch/ALU timeouts.
//
// Ports:
//   clk            core clock, rising edge
//   reset_n        asynchronous active-low reset
//   run_en         level: sequence instructions continuously
//   resume         pulse: leave HALT (skips the EBREAK)
//   clr_err        pulse: leave ERR (wins over resume)
//   instr          fetched instruction
//   instr_valid    instr valid this cycle
//   alu_data_valid ALU result valid (only looked at in EXEC)
//   next_instr     one-cycle fetch request (first FETCH cycle)
//   rs_addr_valid  one-cycle register-file read strobe (DECODE)
//   rd_wr_en       one-cycle register-file write strobe (WB, rd != x0)
//   op_done        one-cycle retire pulse (WB)
//   pc             address of the instruction in flight
//   busy/halted/err  status flags
//   err_code       0 none, 1 fetch timeout, 2 ALU timeout, 3 illegal
//   retire_cnt     retired instructions, saturating
//
// Optional build macro CORE_SEQ_STEP_EN adds:
//   step_req  (in)  pulse: in IDLE with run_en=0, execute a single instruction
//   step_done (out) pulses together with op_done of a stepped instruction
//
// All outputs are registered. They are computed from the next state, so each
// strobe is high during the cycle the FSM spends in the matching state.

module core_seq_ctrl #(
  parameter int              PC_W          = 32,
  parameter logic [PC_W-1:0] RESET_PC      = '0,
  parameter int              FETCH_TIMEOUT = 8,
  parameter int              ALU_TIMEOUT   = 16,
  parameter int              CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run_en,
  input  logic             resume,
  input  logic             clr_err,
  input  logic [31:0]      instr,
  input  logic             instr_valid,
  input  logic             alu_data_valid,
  output logic             next_instr,
  output logic             rs_addr_valid,
  output logic             rd_wr_en,
  output logic             op_done,
  output logic [PC_W-1:0]  pc,
  output logic             busy,
  output logic             halted,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] retire_cnt
`ifdef CORE_SEQ_STEP_EN
  ,
  input  logic             step_req,
  output logic             step_done
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT, S_ERR
  } state_t;

  localparam logic [31:0] EBREAK  = 32'h0010_0073;
  localparam int          TMO_MAX = (FETCH_TIMEOUT > ALU_TIMEOUT) ? FETCH_TIMEOUT : ALU_TIMEOUT;
  localparam int          TMO_W   = $clog2(TMO_MAX + 1);

  state_t           state_reg, state_next;
  logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_inc;
  logic [31:0]      instr_q;
  logic             illegal, is_ebreak, busy_next;

  assign tmo_cnt_inc = tmo_cnt_reg + TMO_W'(1);
  // Low bits other than 2'b11 are compressed/reserved and are not supported.
  // All-zeros and all-ones are the canonical illegal encodings.
  assign illegal     = (instr_q[1:0] != 2'b11) || (instr_q == 32'h0) || (instr_q == 32'hFFFF_FFFF);
  assign is_ebreak   = (instr_q == EBREAK);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (run_en) begin
          state_next = S_FETCH;
        end
`ifdef CORE_SEQ_STEP_EN
        else if (step_req) begin
          state_next = S_FETCH;
        end
`endif
      end
      S_FETCH: begin
        if (instr_valid) begin
          state_next = S_DECODE;
        end else if (tmo_cnt_inc == TMO_W'(FETCH_TIMEOUT)) begin
          state_next = S_ERR;
        end
      end
      S_DECODE: begin
        if (illegal) begin
          state_next = S_ERR;
        end else if (is_ebreak) begin
          state_next = S_HALT;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (alu_data_valid) begin
          state_next = S_WB;
        end else if (tmo_cnt_inc == TMO_W'(ALU_TIMEOUT)) begin
          state_next = S_ERR;
        end
      end
      S_WB:   state_next = run_en ? S_FETCH : S_IDLE;
      S_HALT: if (resume) state_next = S_FETCH;
      S_ERR:  if (clr_err) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign busy_next = (state_next != S_IDLE) && (state_next != S_HALT) && (state_next != S_ERR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= S_IDLE;
      tmo_cnt_reg   <= '0;
      instr_q       <= '0;
      pc            <= RESET_PC;
      retire_cnt    <= '0;
      err_code      <= 2'd0;
      next_instr    <= 1'b0;
      rs_addr_valid <= 1'b0;
      rd_wr_en      <= 1'b0;
      op_done       <= 1'b0;
      busy          <= 1'b0;
      halted        <= 1'b0;
      err           <= 1'b0;
    end else begin
      state_reg     <= state_next;
      next_instr    <= (state_next == S_FETCH) && (state_reg != S_FETCH);
      rs_addr_valid <= (state_next == S_DECODE);
      op_done       <= (state_next == S_WB);
      rd_wr_en      <= (state_next == S_WB) && (instr_q[11:7] != 5'd0);
      busy          <= busy_next;
      halted        <= (state_next == S_HALT);
      err           <= (state_next == S_ERR);

      // One counter serves both wait states; it restarts on every state change.
      if (state_next != state_reg) begin
        tmo_cnt_reg <= '0;
      end else if ((state_reg == S_FETCH) || (state_reg == S_EXEC)) begin
        tmo_cnt_reg <= tmo_cnt_inc;
      end

      if ((state_reg == S_FETCH) && instr_valid) begin
        instr_q <= instr;
      end

      // PC moves on retire, or on resume to step over the EBREAK.
      if ((state_reg == S_WB) || ((state_reg == S_HALT) && resume)) begin
        pc <= pc + PC_W'(4);
      end

      if ((state_reg == S_WB) && (retire_cnt != '1)) begin
        retire_cnt <= retire_cnt + CNT_W'(1);
      end

      if ((state_reg == S_ERR) && clr_err) begin
        err_code <= 2'd0;
      end else if ((state_next == S_ERR) && (state_reg != S_ERR)) begin
        err_code <= (state_reg == S_FETCH) ? 2'd1 :
                    (state_reg == S_EXEC)  ? 2'd2 : 2'd3;
      end
    end
  end

`ifdef CORE_SEQ_STEP_EN
  // Marks an instruction launched by step_req; it is dropped whenever the
  // sequencer stops being busy, so a halt/error also ends the step.
  logic step_mode_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_mode_reg <= 1'b0;
      step_done     <= 1'b0;
    end else begin
      step_done <= (state_next == S_WB) && step_mode_reg;
      if ((state_reg == S_IDLE) && !run_en && step_req) begin
        step_mode_reg <= 1'b1;
      end else if (!busy_next) begin
        step_mode_reg <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Testbench for core_seq_ctrl. It plays instruction memory and ALU with random
// wait times, and it checks the DUT against a transaction-level expectation.
// That expectation is: expected PC advances by 4 per retire, the retire count
// saturates, the write strobe follows rd, and the fetch-to-fetch period is
// 4 + memory wait + ALU wait.
module tb_core_seq_ctrl;
  localparam int PC_W  = 32;
  localparam int CNT_W = 4;   // narrow counter so saturation is reachable
  localparam int FT    = 8;
  localparam int AT    = 16;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             run_en = 1'b0;
  logic             resume = 1'b0;
  logic             clr_err = 1'b0;
  logic [31:0]      instr = '0;
  logic             instr_valid = 1'b0;
  logic             alu_data_valid = 1'b0;
  logic             next_instr, rs_addr_valid, rd_wr_en, op_done;
  logic [PC_W-1:0]  pc;
  logic             busy, halted, err;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] retire_cnt;
`ifdef CORE_SEQ_STEP_EN
  logic             step_req = 1'b0;
  logic             step_done;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [PC_W-1:0]  exp_pc;
  logic [CNT_W-1:0] exp_ret;

  core_seq_ctrl #(.PC_W(PC_W), .FETCH_TIMEOUT(FT), .ALU_TIMEOUT(AT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .run_en(run_en), .resume(resume), .clr_err(clr_err),
    .instr(instr), .instr_valid(instr_valid), .alu_data_valid(alu_data_valid),
    .next_instr(next_instr), .rs_addr_valid(rs_addr_valid), .rd_wr_en(rd_wr_en),
    .op_done(op_done), .pc(pc), .busy(busy), .halted(halted), .err(err),
    .err_code(err_code), .retire_cnt(retire_cnt)
`ifdef CORE_SEQ_STEP_EN
    , .step_req(step_req), .step_done(step_done)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    chk("strobe_excl", 64'($countones({next_instr, rs_addr_valid, rd_wr_en}) <= 1), 64'd1);
  endtask

  function automatic logic [31:0] rand_legal();
    logic [31:0] v;
    do begin
      v = $urandom();
      v[1:0] = 2'b11;
    end while ((v == 32'hFFFF_FFFF) || (v == EBREAK));
    return v;
  endfunction

  // Entered with the first FETCH cycle just observed. mw = memory wait cycles,
  // aw = extra EXEC cycles, keep_run=0 drops run_en while in EXEC.
  task automatic do_instr(input logic [31:0] ins, input int mw, input int aw, input logic keep_run);
    int start;
    start = cyc;
    chk("fetch_req", 64'(next_instr), 64'd1);
    chk("fetch_pc", 64'(pc), 64'(exp_pc));
    chk("fetch_busy", 64'(busy), 64'd1);
    for (int i = 0; i < mw; i++) begin
      instr_valid = 1'b0;
      instr = $urandom();
      alu_data_valid = 1'($urandom_range(0, 1));
      tick();
      chk("fetch_wait_req", 64'(next_instr), 64'd0);
      chk("fetch_wait_dec", 64'(rs_addr_valid), 64'd0);
    end
    instr_valid = 1'b1;
    instr = ins;
    tick();
    instr_valid = 1'b0;
    instr = $urandom();
    chk("decode_strobe", 64'(rs_addr_valid), 64'd1);
    alu_data_valid = 1'($urandom_range(0, 1));   // must be ignored in DECODE
    tick();
    chk("exec_quiet", 64'({next_instr, rs_addr_valid, rd_wr_en, op_done}), 64'd0);
    if (!keep_run) run_en = 1'b0;
    for (int k = 0; k < aw; k++) begin
      alu_data_valid = 1'b0;
      tick();
      chk("exec_wait", 64'({op_done, busy}), 64'b01);
    end
    alu_data_valid = 1'b1;
    tick();
    alu_data_valid = 1'b0;
    chk("wb_done", 64'(op_done), 64'd1);
    chk("wb_wr", 64'(ins[11:7] != 5'd0), 64'(rd_wr_en));
    chk("wb_pc", 64'(pc), 64'(exp_pc));
    exp_pc = exp_pc + 4;
    if (exp_ret != '1) exp_ret = exp_ret + 1'b1;
    tick();
    chk("retire_cnt", 64'(retire_cnt), 64'(exp_ret));
    chk("next_pc", 64'(pc), 64'(exp_pc));
    if (keep_run) begin
      chk("refetch", 64'(next_instr), 64'd1);
      chk("period", 64'(cyc - start), 64'(4 + mw + aw));
    end else begin
      chk("idle_after", 64'({busy, next_instr, op_done}), 64'd0);
    end
  endtask

  initial begin
    logic [31:0] bad_tab [3];
    logic [31:0] v;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc", 64'(pc), 64'd0);
    chk("rst_ret", 64'(retire_cnt), 64'd0);
    chk("rst_flags", 64'({busy, halted, err, err_code}), 64'd0);
    chk("rst_strobes", 64'({next_instr, rs_addr_valid, rd_wr_en, op_done}), 64'd0);
    reset_n = 1'b1;
    exp_pc = '0;
    exp_ret = '0;
    tick();
    chk("idle_no_run", 64'({busy, next_instr}), 64'd0);

    // addi x1,x0,5 with one-cycle memory, then three zero-wait instructions
    run_en = 1'b1;
    tick();
    do_instr(32'h0050_0093, 1, 0, 1'b1);
    do_instr(32'h0000_0013, 0, 0, 1'b1);
    do_instr(rand_legal(), 0, 0, 1'b1);
    do_instr(rand_legal(), 0, 0, 1'b1);

    // Randomized stream; pushes the 4-bit retire counter into saturation
    for (int n = 0; n < 20; n++) begin
      v = rand_legal();
      if (n % 4 == 0) v[11:7] = 5'd0;
      do_instr(v, $urandom_range(0, 3), $urandom_range(0, 4), 1'b1);
    end

    // Fetch timeout, then clr_err together with resume
    instr_valid = 1'b0;
    for (int i = 1; i < FT; i++) begin
      tick();
      chk("fetch_tmo_wait", 64'({busy, err}), 64'b10);
    end
    tick();
    chk("fetch_tmo_err", 64'({err, err_code, busy}), 64'b1_01_0);
    chk("fetch_tmo_pc", 64'(pc), 64'(exp_pc));
    run_en = 1'b0;
    tick();
    chk("err_hold", 64'({err, err_code}), 64'b1_01);
    clr_err = 1'b1;
    resume = 1'b1;
    tick();
    clr_err = 1'b0;
    resume = 1'b0;
    chk("clr_err_idle", 64'({err, err_code, halted, busy, next_instr}), 64'd0);
    chk("clr_err_pc", 64'(pc), 64'(exp_pc));

    // Illegal encodings
    bad_tab[0] = 32'hFFFF_FFFF;
    bad_tab[1] = 32'h0000_0000;
    v = $urandom();
    v[1:0] = 2'b01;
    bad_tab[2] = v;
    run_en = 1'b1;
    tick();
    for (int j = 0; j < 3; j++) begin
      chk("ill_fetch", 64'(next_instr), 64'd1);
      instr_valid = 1'b1;
      instr = bad_tab[j];
      tick();
      instr_valid = 1'b0;
      chk("ill_decode", 64'(rs_addr_valid), 64'd1);
      tick();
      chk("ill_err", 64'({err, err_code, op_done, rd_wr_en}), 64'b1_11_00);
      chk("ill_pc", 64'(pc), 64'(exp_pc));
      chk("ill_ret", 64'(retire_cnt), 64'(exp_ret));
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("ill_clr", 64'({err, err_code}), 64'd0);
      tick();
    end

    // ALU timeout
    chk("alu_tmo_fetch", 64'(next_instr), 64'd1);
    instr_valid = 1'b1;
    instr = rand_legal();
    tick();
    instr_valid = 1'b0;
    alu_data_valid = 1'b0;
    tick();
    for (int i = 1; i < AT; i++) begin
      tick();
      chk("alu_tmo_wait", 64'({busy, err}), 64'b10);
    end
    tick();
    chk("alu_tmo_err", 64'({err, err_code, op_done, rd_wr_en}), 64'b1_10_00);
    chk("alu_tmo_ret", 64'(retire_cnt), 64'(exp_ret));
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    tick();

    // run_en dropped in EXEC: instruction completes, then IDLE with no fetch
    do_instr(rand_legal(), 0, 1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("run_off_idle", 64'({busy, next_instr}), 64'd0);
    end

    // Asynchronous reset during EXEC
    run_en = 1'b1;
    tick();
    instr_valid = 1'b1;
    instr = 32'h0050_0093;
    tick();
    instr_valid = 1'b0;
    tick();
    alu_data_valid = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_pc", 64'(pc), 64'd0);
    chk("async_rst_ret", 64'(retire_cnt), 64'd0);
    chk("async_rst_flags", 64'({busy, rd_wr_en, op_done, err_code}), 64'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_no_wb", 64'({rd_wr_en, op_done, busy}), 64'd0);
    end
    alu_data_valid = 1'b0;
    run_en = 1'b0;
    reset_n = 1'b1;
    exp_pc = '0;
    exp_ret = '0;
    tick();
    chk("post_rst_idle", 64'(busy), 64'd0);

    // EBREAK at pc=8
    run_en = 1'b1;
    tick();
    do_instr(32'h0050_0093, 0, 0, 1'b1);
    do_instr(32'h0000_0013, 0, 0, 1'b1);
    instr_valid = 1'b1;
    instr = EBREAK;
    tick();
    instr_valid = 1'b0;
    tick();
    chk("halt_flags", 64'({halted, busy, op_done, rd_wr_en}), 64'b1000);
    chk("halt_pc", 64'(pc), 64'(exp_pc));
    chk("halt_ret", 64'(retire_cnt), 64'(exp_ret));
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("halt_hold", 64'({halted, next_instr}), 64'b10);
    end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    exp_pc = exp_pc + 4;
    chk("resume_fetch", 64'({next_instr, halted, busy}), 64'b101);
    chk("resume_pc", 64'(pc), 64'(exp_pc));
    chk("resume_ret", 64'(retire_cnt), 64'(exp_ret));
    do_instr(rand_legal(), 0, 0, 1'b0);

`ifdef CORE_SEQ_STEP_EN
    // Single step from IDLE
    tick();
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    chk("step_fetch", 64'({next_instr, busy}), 64'b11);
    instr_valid = 1'b1;
    instr = rand_legal();
    tick();
    instr_valid = 1'b0;
    tick();
    alu_data_valid = 1'b1;
    tick();
    alu_data_valid = 1'b0;
    chk("step_done", 64'({step_done, op_done}), 64'b11);
    tick();
    chk("step_idle", 64'({step_done, busy, next_instr}), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
- Multi-cycle instruction sequencer for the single-issue RV32 core.
- Fetches from the instruction memory, strobes the decoder/register-file read, waits for the ALU result, then commits the writeback.
- Maintains the PC and retire count; detects halts, illegal encodings and fetch/ALU timeouts.
- Sits between the instruction memory, decoder, register file and ALU, and owns every sequencing strobe.

Parameters:
- PC_W, 32, PC width in bits.
- RESET_PC, 0, PC value after reset.
- FETCH_TIMEOUT, 8, max cycles waiting for instr_valid after a fetch request.
- ALU_TIMEOUT, 16, max cycles waiting for alu_data_valid in EXEC.
- CNT_W, 32, retire counter width.

Ports:
- clk  in  1  core clock, rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- run_en  in  1  level; 1 = sequence instructions continuously.
- resume  in  1  pulse; leave HALT.
- clr_err  in  1  pulse; leave ERR.
- instr  in  32  fetched instruction.
- instr_valid  in  1  instr is valid this cycle.
- alu_data_valid  in  1  ALU result valid.
- next_instr  out  1  one-cycle fetch request to instruction memory.
- rs_addr_valid  out  1  one-cycle register-file read strobe.
- rd_wr_en  out  1  one-cycle register-file write strobe.
- op_done  out  1  one-cycle retire/ack pulse.
- pc  out  PC_W  address of the instruction currently in flight.
- busy  out  1  1 in any state except IDLE/HALT/ERR.
- halted  out  1  1 in HALT.
- err  out  1  1 in ERR.
- err_code  out  2  0 none, 1 fetch timeout, 2 ALU timeout, 3 illegal.
- retire_cnt  out  CNT_W  instructions retired.

Behaviour:
- Reset (async assert, sync deassert): state=IDLE, pc=RESET_PC, retire_cnt=0, err_code=0, all strobes 0, instr_q=0, timeout counter=0. Asserting reset_n low mid-instruction aborts the instruction with no writeback.
- All outputs are registered.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT, ERR.
- IDLE: if run_en=1, go to FETCH next cycle.
- FETCH:
  - next_instr=1 on the first FETCH cycle only.
  - Counter increments each cycle instr_valid=0.
  - On instr_valid=1 (including the request cycle), capture instr into instr_q and go to DECODE.
  - Counter reaching FETCH_TIMEOUT with no instr_valid: ERR, err_code=1.
- DECODE (exactly 1 cycle): rs_addr_valid=1. Check instr_q, in priority order:
  - instr_q[1:0]!=2'b11 or instr_q==32'h0 or instr_q==32'hFFFFFFFF: ERR, err_code=3.
  - instr_q==32'h00100073 (EBREAK): HALT. EBREAK is not retired and pc stays on it.
  - Otherwise: EXEC.
- EXEC:
  - Wait for alu_data_valid=1, then go to WB.
  - Counter (cleared on entry) reaching ALU_TIMEOUT: ERR, err_code=2.
  - alu_data_valid outside EXEC is ignored.
- WB (exactly 1 cycle):
  - rd_wr_en=1 if instr_q[11:7]!=0, else 0.
  - op_done=1; pc<=pc+4, wrapping modulo 2^PC_W; retire_cnt<=retire_cnt+1, saturating at all-ones.
  - Next state: FETCH if run_en=1, else IDLE.
- Latency per instruction with zero-wait memory/ALU: FETCH 1, DECODE 1, EXEC 1, WB 1 = 4 cycles.
- run_en deasserted mid-instruction: the current instruction completes through WB, then IDLE. run_en has no effect in FETCH/DECODE/EXEC.
- HALT:
  - resume=1: FETCH with pc<=pc+4 (skips the EBREAK); retire_cnt unchanged.
  - resume in any other state is ignored.
- ERR:
  - Holds pc and err_code.
  - clr_err=1: err_code<=0, then IDLE; pc unchanged.
  - If clr_err and resume are high together, clr_err wins in ERR; resume is ignored.
- At most one of next_instr/rs_addr_valid/rd_wr_en is high in any cycle.

Optional Feature:
- Macro: CORE_SEQ_STEP_EN.
- Defined:
  - Adds input step_req (1 bit, pulse).
  - In IDLE with run_en=0, step_req=1 executes exactly one instruction (FETCH to WB), then returns to IDLE.
  - step_req while busy is ignored.
  - Adds output step_done (1 bit): pulses together with the op_done of a stepped instruction; reset value 0.
- Undefined: no step_req/step_done ports; IDLE leaves only on run_en.

Test Plan:
- Reset, run_en=1, memory returns instr=32'h00500093 (addi x1,x0,5) 1 cycle after next_instr, ALU valid in 1 cycle -> rd_wr_en and op_done pulse together; pc 0->4; retire_cnt=1; next_instr re-asserts the following cycle.
- Stream 3 instructions with zero wait -> next_instr pulses exactly every 4 cycles; retire_cnt=3; pc=12.
- Instruction with rd=0 (32'h00000013) -> op_done=1, rd_wr_en stays 0, pc advances by 4.
- instr_valid withheld for 8 cycles -> err=1, err_code=1, busy=0; clr_err -> IDLE, err_code=0, pc unchanged.
- instr=32'h00100073 at pc=8 -> halted=1, pc=8, retire_cnt unchanged; resume -> FETCH with pc=12. Separately, instr=32'hFFFFFFFF -> err_code=3.
- Drop reset_n during EXEC; drop run_en during EXEC -> reset case: asynchronously pc=0, retire_cnt=0, no rd_wr_en. run_en case: WB completes, then IDLE with no further next_instr.
